pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Consumer side of the next-PC path. Holds the architectural PC register.
- Issues one instruction-memory fetch per instruction and presents the fetched word to the decode/execute datapath.
- Accepts the next-PC value computed downstream and advances the PC only when the current instruction is consumed.
- Sits between instruction memory and the core's decode stage. Single outstanding fetch; no prefetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VEC, 32'h0000_0100, redirect target for a misaligned next-PC (used only with the optional feature).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- npc  input  32  next PC from the next-PC logic; sampled only on instruction consume.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_addr  output  32  fetch address (equals pc while request pending).
- imem_rsp_valid  input  1  fetch data valid (single-cycle pulse).
- imem_rsp_data  input  32  fetched instruction word.
- inst_valid  output  1  instruction held for decode.
- inst_ready  input  1  core consumes the held instruction this cycle.
- inst  output  32  held instruction word.
- pc  output  32  PC of the held / in-flight instruction.
- fetch_cnt  output  32  count of instructions consumed.
- misalign  output  1  one-cycle pulse on misaligned npc (0 when feature compiled out).

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, state=ISSUE, inst=0, inst_valid=0, imem_req_valid=0, fetch_cnt=0, misalign=0.
  - Reset asserted in any state aborts that operation.
  - The memory is reset with the same rst, so no pre-reset response is delivered.
- States: ISSUE, WAIT, HOLD. Registered outputs are derived from state.
  - imem_req_valid=1 iff state=ISSUE and not in the cycle directly after reset (first request in cycle 2 after rst falls).
  - inst_valid=1 iff state=HOLD.
- ISSUE:
  - imem_addr=pc.
  - imem_req_ready=1 -> WAIT. Otherwise stay; imem_addr must stay stable while waiting.
- WAIT:
  - imem_req_valid=0.
  - imem_rsp_valid=1 -> inst<=imem_rsp_data, go HOLD.
  - A response never coincides with request acceptance; minimum latency is 1 cycle after accept.
  - imem_rsp_valid outside WAIT is ignored.
- HOLD:
  - inst and pc remain stable until consumed.
  - inst_ready=1 -> pc<=npc, fetch_cnt<=fetch_cnt+1 (wraps 32'hFFFF_FFFF->0), go ISSUE.
  - inst_ready=0 -> stay, no change.
- Latency: with zero-wait memory (req_ready=1, rsp the next cycle) and inst_ready=1, throughput is one instruction every 3 cycles. Cycle pattern: ISSUE, WAIT, HOLD.
- npc is used without arithmetic; full 32 bits, no masking (feature off).
- inst_ready in ISSUE or WAIT has no effect.

Optional Feature:
- Macro: PC_FETCH_MISALIGN_TRAP_EN.
- Enabled: on consume, if npc[1:0]!=2'b00, then pc<=TRAP_VEC and misalign=1 for exactly one cycle (the cycle after consume). fetch_cnt still increments.
- Disabled: npc is loaded unchecked and misalign is tied to 0.

Test Plan:
- Reset release with RESET_PC=0, req_ready=1, rsp after 1 cycle, inst_ready=1, npc=pc+4 -> imem_addr sequence 0x0,0x4,0x8. New request every 3 cycles. fetch_cnt=3 after third consume.
- req_ready held 0 for 4 cycles in ISSUE -> imem_req_valid=1 and imem_addr constant throughout; WAIT entered only on the ready cycle.
- rsp_data=0x00500093, inst_ready held 0 for 5 cycles -> inst=0x00500093 and inst_valid=1 stable; pc unchanged; no new request.
- In HOLD at pc=0x10, npc=0x40 (jump), inst_ready=1 -> next imem_addr=0x40; pc=0x40.
- rst asserted while in WAIT -> next cycle pc=RESET_PC, inst_valid=0, fetch_cnt=0; a stray rsp_valid in ISSUE is ignored.
- Feature on, npc=0x42 consumed -> pc=TRAP_VEC (0x100); misalign pulses 1 cycle. Feature off, same stimulus -> pc=0x42, misalign=0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: holds the architectural PC, issues one fetch per instruction, and holds the word for decode.
// Optional misaligned next-PC trap is enabled by defining PC_FETCH_MISALIGN_TRAP_EN.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] fetch_cnt,
    output logic        misalign
);

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic [31:0] cnt_q;
    logic        just_reset_q;
    logic        consume;

    // The first cycle after reset keeps the request low so memory sees a clean start.
    assign imem_req_valid = (state_q == ISSUE) && !just_reset_q;
    assign inst_valid     = (state_q == HOLD);
    assign imem_addr      = pc_q;
    assign pc             = pc_q;
    assign inst           = inst_q;
    assign fetch_cnt      = cnt_q;
    assign consume        = (state_q == HOLD) && inst_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ISSUE: if (imem_req_valid && imem_req_ready) state_d = WAIT;
            WAIT:  if (imem_rsp_valid) state_d = HOLD;
            HOLD:  if (inst_ready) state_d = ISSUE;
            default: state_d = ISSUE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ISSUE;
            just_reset_q <= 1'b1;
            inst_q       <= 32'h0;
        end else begin
            state_q      <= state_d;
            just_reset_q <= 1'b0;
            if ((state_q == WAIT) && imem_rsp_valid) begin
                inst_q <= imem_rsp_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 32'h0;
        end else if (consume) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

`ifdef PC_FETCH_MISALIGN_TRAP_EN
    logic misalign_q;

    // A misaligned target redirects to the trap vector instead of being fetched.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            if (consume) begin
                if (npc[1:0] != 2'b00) begin
                    pc_q       <= TRAP_VEC;
                    misalign_q <= 1'b1;
                end else begin
                    pc_q <= npc;
                end
            end
        end
    end

    assign misalign = misalign_q;
`else
    logic unused_trap_vec;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (consume) begin
            pc_q <= npc;
        end
    end

    assign misalign        = 1'b0;
    assign unused_trap_vec = ^TRAP_VEC;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed testbench for pc_fetch_unit; expectations follow PC_FETCH_MISALIGN_TRAP_EN when defined.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] npc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] fetch_cnt;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    pc_fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .TRAP_VEC(32'h0000_0100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .npc(npc),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst(inst),
        .pc(pc),
        .fetch_cnt(fetch_cnt),
        .misalign(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are checked at the falling edge, away from the active edge.
    task automatic applyStimulus(input logic r, input logic rq_rdy, input logic rs_vld,
                                 input logic [31:0] rs_data, input logic i_rdy,
                                 input logic [31:0] n);
        rst            = r;
        imem_req_ready = rq_rdy;
        imem_rsp_valid = rs_vld;
        imem_rsp_data  = rs_data;
        inst_ready     = i_rdy;
        npc            = n;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;

    initial begin
        rst = 1'b1; npc = '0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        imem_rsp_data = '0; inst_ready = 1'b0;
        @(negedge clk);
        applyStimulus(1, 0, 0, 32'h0, 0, 32'h0);

        // Reset state, including the quiet cycle right after the reset edge.
        checkOutput("rst_pc", pc, 32'h0);
        checkOutput("rst_inst", inst, 32'h0);
        checkOutput("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
        checkOutput("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        checkOutput("rst_fetch_cnt", fetch_cnt, 32'h0);
        checkOutput("rst_misalign", {31'b0, misalign}, 32'h0);

        applyStimulus(0, 1, 0, 32'h0, 0, 32'h0);
        checkOutput("first_req_valid", {31'b0, imem_req_valid}, 32'h1);
        checkOutput("first_addr", imem_addr, 32'h0);

        // Zero-wait stream: one instruction every three cycles, sequential PCs.
        exp_pc = 32'h0;
        exp_cnt = 32'h0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("seq_issue_valid", {31'b0, imem_req_valid}, 32'h1);
            checkOutput("seq_issue_addr", imem_addr, exp_pc);
            applyStimulus(0, 1, 0, 32'h0, 1, 32'h0);
            checkOutput("seq_wait_req", {31'b0, imem_req_valid}, 32'h0);
            checkOutput("seq_wait_inst_valid", {31'b0, inst_valid}, 32'h0);
            applyStimulus(0, 0, 1, 32'hA000_0000 + i, 1, 32'h0);
            checkOutput("seq_hold_valid", {31'b0, inst_valid}, 32'h1);
            checkOutput("seq_hold_inst", inst, 32'hA000_0000 + i);
            checkOutput("seq_hold_pc", pc, exp_pc);
            applyStimulus(0, 1, 0, 32'h0, 1, exp_pc + 32'd4);
            exp_pc  = exp_pc + 32'd4;
            exp_cnt = exp_cnt + 32'd1;
            checkOutput("seq_cnt", fetch_cnt, exp_cnt);
            checkOutput("seq_pc", pc, exp_pc);
        end
        checkOutput("seq_cnt_final", fetch_cnt, 32'd3);

        // Back-pressured request: address and valid must hold steady.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 32'h0, 0, 32'h0);
            checkOutput("stall_req_valid", {31'b0, imem_req_valid}, 32'h1);
            checkOutput("stall_addr", imem_addr, 32'hC);
            checkOutput("stall_inst_valid", {31'b0, inst_valid}, 32'h0);
        end
        applyStimulus(0, 1, 0, 32'h0, 0, 32'h0);
        checkOutput("stall_accept_wait", {31'b0, imem_req_valid}, 32'h0);

        // Held instruction stays put while decode stalls; stray responses are ignored.
        applyStimulus(0, 0, 1, 32'h0050_0093, 0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, (i == 2), 32'hDEAD_BEEF, 0, 32'h0);
            checkOutput("hold_inst", inst, 32'h0050_0093);
            checkOutput("hold_valid", {31'b0, inst_valid}, 32'h1);
            checkOutput("hold_pc", pc, 32'hC);
            checkOutput("hold_no_req", {31'b0, imem_req_valid}, 32'h0);
        end
        applyStimulus(0, 1, 0, 32'h0, 1, 32'h10);
        checkOutput("consume_pc", pc, 32'h10);
        checkOutput("consume_cnt", fetch_cnt, 32'd4);

        // Jump: pc 0x10 -> 0x40.
        applyStimulus(0, 1, 0, 32'h0, 0, 32'h0);
        applyStimulus(0, 0, 1, 32'h0000_0013, 0, 32'h0);
        checkOutput("jump_hold_pc", pc, 32'h10);
        applyStimulus(0, 0, 0, 32'h0, 1, 32'h40);
        checkOutput("jump_addr", imem_addr, 32'h40);
        checkOutput("jump_pc", pc, 32'h40);
        checkOutput("jump_req_valid", {31'b0, imem_req_valid}, 32'h1);
        checkOutput("jump_cnt", fetch_cnt, 32'd5);

        // Reset while waiting for a response, then a stray response in ISSUE.
        applyStimulus(0, 1, 0, 32'h0, 0, 32'h0);
        checkOutput("pre_rst_wait", {31'b0, imem_req_valid}, 32'h0);
        applyStimulus(1, 0, 0, 32'h0, 0, 32'h0);
        checkOutput("mid_rst_pc", pc, 32'h0);
        checkOutput("mid_rst_inst_valid", {31'b0, inst_valid}, 32'h0);
        checkOutput("mid_rst_cnt", fetch_cnt, 32'h0);
        checkOutput("mid_rst_req", {31'b0, imem_req_valid}, 32'h0);
        applyStimulus(0, 0, 1, 32'hBAD0_BAD0, 0, 32'h0);
        applyStimulus(0, 0, 1, 32'hBAD0_BAD0, 0, 32'h0);
        checkOutput("stray_rsp_inst_valid", {31'b0, inst_valid}, 32'h0);
        checkOutput("stray_rsp_inst", inst, 32'h0);
        checkOutput("stray_rsp_req", {31'b0, imem_req_valid}, 32'h1);

        // Misaligned next-PC.
        applyStimulus(0, 1, 0, 32'h0, 0, 32'h0);
        applyStimulus(0, 0, 1, 32'h0000_0033, 0, 32'h0);
        checkOutput("mis_hold_valid", {31'b0, inst_valid}, 32'h1);
        applyStimulus(0, 0, 0, 32'h0, 1, 32'h42);
`ifdef PC_FETCH_MISALIGN_TRAP_EN
        checkOutput("mis_pc", pc, 32'h100);
        checkOutput("mis_pulse", {31'b0, misalign}, 32'h1);
`else
        checkOutput("mis_pc", pc, 32'h42);
        checkOutput("mis_pulse", {31'b0, misalign}, 32'h0);
`endif
        checkOutput("mis_cnt", fetch_cnt, 32'd1);
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0);
        checkOutput("mis_pulse_end", {31'b0, misalign}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
